// File: rtl/slc3_mem_responder_if.sv
// SLC-3 memory bus between the control unit (master) and the memory responder (slave).
// Strobes are active-low; mem_ready is a one-cycle completion pulse.
interface slc3_mem_responder_if;
  logic        Mem_CE;
  logic        Mem_UB;
  logic        Mem_LB;
  logic        Mem_OE;
  logic        Mem_WE;
  logic [15:0] ADDR;
  logic [15:0] Data_in;
  logic [15:0] Data_out;
  logic        mem_ready;

  modport master (
    output Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    input  Data_out, mem_ready
  );

  modport slave (
    input  Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, ADDR, Data_in,
    output Data_out, mem_ready
  );
endinterface

// File: rtl/slc3_mem_responder.sv
// Memory-side responder for SLC-3 strobes: wait-state insertion, one mem_ready pulse per access.
// Define SLC3_MMIO_EN to map 16'hFFFF to Switches (read) and Hex_out (write).
module slc3_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  slc3_mem_responder_if.slave  bus,
  input  logic [15:0]          Switches,
  output logic [15:0]          Hex_out,
  output logic                 busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [15:0] addr_r;
  logic [15:0] wdata_r;
  logic        ub_n_r;
  logic        lb_n_r;
  logic        is_write_r;
  logic [15:0] data_out_r;
  logic [15:0] hex_r;
  logic        ready_r;
  logic        busy_r;
  logic [15:0] mem_r [0:(1 << ADDR_W) - 1];

  logic        start_s;
  logic        release_s;
  logic        load_rd_s;
  logic        mem_we_s;
  logic        wr_mmio_s;
  logic [15:0] rd_addr_s;
  logic        rd_ub_n_s;
  logic        rd_lb_n_s;
  logic [15:0] rd_word_s;
  logic [15:0] rd_src_s;
  logic [15:0] rd_data_s;

  function automatic logic [15:0] lane_mask(input logic ub_n, input logic lb_n);
    return {{8{~ub_n}}, {8{~lb_n}}};
  endfunction

  function automatic logic [15:0] lane_merge(input logic [15:0] old_v, input logic [15:0] new_v,
                                             input logic [15:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Strobe decode and the per-state read-load / write-commit enables.
  always_comb begin
    start_s   = 1'b0;
    release_s = 1'b0;
    load_rd_s = 1'b0;
    mem_we_s  = 1'b0;
    start_s   = !bus.Mem_CE && (!bus.Mem_WE || !bus.Mem_OE);
    release_s = bus.Mem_CE || (bus.Mem_OE && bus.Mem_WE);
    case (state_r)
      ST_IDLE: begin
        // Zero-wait reads must register Data_out on the capture edge itself.
        if (start_s && bus.Mem_WE && (WAIT_INIT == 4'd0)) begin
          load_rd_s = 1'b1;
        end else begin
          load_rd_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!is_write_r && (cnt_r <= 4'd1)) begin
          load_rd_s = 1'b1;
        end else begin
          load_rd_s = 1'b0;
        end
      end
      ST_READY: begin
        if (is_write_r && !wr_mmio_s) begin
          mem_we_s = 1'b1;
        end else begin
          mem_we_s = 1'b0;
        end
      end
      default: begin
        load_rd_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // Read data path: live bus while idle, latched request once an access is in flight.
  always_comb begin
    rd_addr_s = addr_r;
    rd_ub_n_s = ub_n_r;
    rd_lb_n_s = lb_n_r;
    if (state_r == ST_IDLE) begin
      rd_addr_s = bus.ADDR;
      rd_ub_n_s = bus.Mem_UB;
      rd_lb_n_s = bus.Mem_LB;
    end else begin
      rd_addr_s = addr_r;
      rd_ub_n_s = ub_n_r;
      rd_lb_n_s = lb_n_r;
    end
    rd_word_s = mem_r[rd_addr_s[ADDR_W-1:0]];
`ifdef SLC3_MMIO_EN
    if (rd_addr_s == 16'hFFFF) begin
      rd_src_s = Switches;
    end else begin
      rd_src_s = rd_word_s;
    end
    wr_mmio_s = (addr_r == 16'hFFFF);
`else
    rd_src_s  = rd_word_s;
    wr_mmio_s = 1'b0;
`endif
    rd_data_s = rd_src_s & lane_mask(rd_ub_n_s, rd_lb_n_s);
  end

  // Access FSM with registered mem_ready, busy, Data_out and Hex_out.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 16'h0000;
      wdata_r    <= 16'h0000;
      ub_n_r     <= 1'b1;
      lb_n_r     <= 1'b1;
      is_write_r <= 1'b0;
      data_out_r <= 16'h0000;
      hex_r      <= 16'h0000;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      if (load_rd_s) begin
        data_out_r <= rd_data_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start_s) begin
            addr_r     <= bus.ADDR;
            wdata_r    <= bus.Data_in;
            ub_n_r     <= bus.Mem_UB;
            lb_n_r     <= bus.Mem_LB;
            is_write_r <= !bus.Mem_WE;
            cnt_r      <= WAIT_INIT;
            busy_r     <= 1'b1;
            if (WAIT_INIT == 4'd0) begin
              state_r <= ST_READY;
              ready_r <= 1'b1;
            end else begin
              state_r <= ST_WAIT;
              ready_r <= 1'b0;
            end
          end else begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
          end
        end
        ST_WAIT: begin
          // Strobes are deliberately ignored here; the access always runs to completion.
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r <= 4'd1) begin
            state_r <= ST_READY;
            ready_r <= 1'b1;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_READY: begin
          state_r <= ST_HOLD;
          ready_r <= 1'b0;
`ifdef SLC3_MMIO_EN
          if (is_write_r && wr_mmio_s) begin
            hex_r <= lane_merge(hex_r, wdata_r, lane_mask(ub_n_r, lb_n_r));
          end
`endif
        end
        ST_HOLD: begin
          ready_r <= 1'b0;
          if (release_s) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= ST_HOLD;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ready_r <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Array write commits on the edge leaving READY, enabled lanes only, never while in reset.
  always_ff @(posedge Clk) begin
    if (Reset && mem_we_s) begin
      if (!ub_n_r) begin
        mem_r[addr_r[ADDR_W-1:0]][15:8] <= wdata_r[15:8];
      end
      if (!lb_n_r) begin
        mem_r[addr_r[ADDR_W-1:0]][7:0] <= wdata_r[7:0];
      end
    end
  end

  assign bus.Data_out  = data_out_r;
  assign bus.mem_ready = ready_r;
  assign Hex_out       = hex_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Bench for slc3_mem_responder: two instances (WAIT_CYCLES=2 and 0) share one bus stimulus
// and are checked against a word-array reference model.
module tb_slc3_mem_responder;
  localparam int AW    = 10;
  localparam int WC    = 2;
  localparam int DEPTH = 1 << AW;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b0;
  logic        ce_n     = 1'b1;
  logic        ub_n     = 1'b1;
  logic        lb_n     = 1'b1;
  logic        oe_n     = 1'b1;
  logic        we_n     = 1'b1;
  logic [15:0] addr     = 16'h0000;
  logic [15:0] wdata    = 16'h0000;
  logic [15:0] switches = 16'h0000;
  logic [15:0] hex_m, hex_z;
  logic        busy_m, busy_z;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem_m [0:DEPTH-1];
  logic [15:0] last_rd = 16'h0000;
  logic [15:0] hex_exp = 16'h0000;

  int          pos_m, cnt_m, pos_z, cnt_z;
  logic [15:0] do_m, do_z;
  bit          busy_hold, busy_rel;

  always #5 clk = ~clk;

  slc3_mem_responder_if bus_m ();
  slc3_mem_responder_if bus_z ();

  assign bus_m.Mem_CE = ce_n;   assign bus_z.Mem_CE = ce_n;
  assign bus_m.Mem_UB = ub_n;   assign bus_z.Mem_UB = ub_n;
  assign bus_m.Mem_LB = lb_n;   assign bus_z.Mem_LB = lb_n;
  assign bus_m.Mem_OE = oe_n;   assign bus_z.Mem_OE = oe_n;
  assign bus_m.Mem_WE = we_n;   assign bus_z.Mem_WE = we_n;
  assign bus_m.ADDR   = addr;   assign bus_z.ADDR   = addr;
  assign bus_m.Data_in = wdata; assign bus_z.Data_in = wdata;

  slc3_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(WC)) u_dut (
    .Clk(clk), .Reset(reset_n), .bus(bus_m.slave), .Switches(switches), .Hex_out(hex_m), .busy(busy_m)
  );

  slc3_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut_z (
    .Clk(clk), .Reset(reset_n), .bus(bus_z.slave), .Switches(switches), .Hex_out(hex_z), .busy(busy_z)
  );

  function automatic logic [15:0] lanes(input logic u, input logic l);
    logic [15:0] m;
    m = 16'h0000;
    if (!u) m[15:8] = 8'hFF;
    if (!l) m[7:0]  = 8'hFF;
    return m;
  endfunction

  function automatic bit is_mmio(input logic [15:0] a);
`ifdef SLC3_MMIO_EN
    return a == 16'hFFFF;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] a, input logic u, input logic l);
    if (is_mmio(a)) return switches & lanes(u, l);
    return mem_m[int'(a) % DEPTH] & lanes(u, l);
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [15:0] d, input logic u, input logic l);
    logic [15:0] m;
    m = lanes(u, l);
    if (is_mmio(a)) hex_exp = (hex_exp & ~m) | (d & m);
    else mem_m[int'(a) % DEPTH] = (mem_m[int'(a) % DEPTH] & ~m) | (d & m);
  endtask

  // Drive one access, hold strobes for 'hold' cycles, record what both DUTs did, update the model.
  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        input logic u, input logic l, input int hold);
    @(negedge clk);
    ce_n  = 1'b0;
    we_n  = ~wr;
    oe_n  = wr ? 1'($urandom_range(0, 1)) : 1'b0;
    addr  = a;
    wdata = d;
    ub_n  = u;
    lb_n  = l;
    pos_m = -1; cnt_m = 0; pos_z = -1; cnt_z = 0;
    do_m  = 16'hDEAD; do_z = 16'hDEAD;
    busy_hold = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus_m.mem_ready === 1'b1) begin cnt_m++; if (pos_m < 0) pos_m = i; do_m = bus_m.Data_out; end
      if (bus_z.mem_ready === 1'b1) begin cnt_z++; if (pos_z < 0) pos_z = i; do_z = bus_z.Data_out; end
      if (!(busy_m === 1'b1 && busy_z === 1'b1)) busy_hold = 1'b0;
      if (i == 0) begin
        addr  = 16'($urandom);
        wdata = 16'($urandom);
        ub_n  = 1'($urandom);
        lb_n  = 1'($urandom);
      end
    end
    @(negedge clk);
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1;
    @(posedge clk); #1;
    busy_rel = (busy_m === 1'b0) && (busy_z === 1'b0);
    if (wr) model_write(a, d, u, l);
    else last_rd = model_read(a, u, l);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (bus_m.mem_ready !== 1'b0 || bus_z.mem_ready !== 1'b0 || busy_m !== 1'b0 || busy_z !== 1'b0 ||
        bus_m.Data_out !== 16'h0000 || bus_z.Data_out !== 16'h0000 || hex_m !== 16'h0000 || hex_z !== 16'h0000) begin
      bad++;
      $display("FAIL reset_state: rdy=%b/%b busy=%b/%b dout=%h/%h hex=%h/%h, expected all zero",
               bus_m.mem_ready, bus_z.mem_ready, busy_m, busy_z, bus_m.Data_out, bus_z.Data_out, hex_m, hex_z);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_latency;
    access(1'b1, 16'h0010, 16'hBEEF, 1'b0, 1'b0, 5);
    total++;
    if (pos_m !== WC || cnt_m !== 1 || pos_z !== 0 || cnt_z !== 1) begin
      bad++;
      $display("FAIL write_latency: pos=%0d/%0d cnt=%0d/%0d, expected pos=%0d/0 cnt=1/1", pos_m, pos_z, cnt_m, cnt_z, WC);
    end
    total++;
    if (do_m !== 16'h0000 || do_z !== 16'h0000 || !busy_hold || !busy_rel) begin
      bad++;
      $display("FAIL write_side_effects: dout=%h/%h busy_hold=%0b busy_rel=%0b, expected 0000/0000 1 1", do_m, do_z, busy_hold, busy_rel);
    end
    access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 5);
    total++;
    if (pos_m !== WC || pos_z !== 0 || do_m !== 16'hBEEF || do_z !== 16'hBEEF) begin
      bad++;
      $display("FAIL read_beef: pos=%0d/%0d dout=%h/%h, expected pos=%0d/0 dout=beef", pos_m, pos_z, do_m, do_z, WC);
    end
  endtask

  task automatic test_byte_lanes;
    access(1'b1, 16'h0020, 16'hFFFF, 1'b0, 1'b0, 4);
    access(1'b1, 16'h0020, 16'h1234, 1'b1, 1'b0, 4);
    access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'hFF34 || do_z !== 16'hFF34) begin
      bad++;
      $display("FAIL lane_write_low: dout=%h/%h, expected ff34", do_m, do_z);
    end
    access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b1, 4);
    total++;
    if (do_m !== 16'hFF00 || do_z !== 16'hFF00) begin
      bad++;
      $display("FAIL lane_read_upper: dout=%h/%h, expected ff00", do_m, do_z);
    end
    access(1'b1, 16'h0020, 16'h0000, 1'b1, 1'b1, 4);
    access(1'b0, 16'h0020, 16'h0000, 1'b1, 1'b1, 4);
    total++;
    if (do_m !== 16'h0000 || do_z !== 16'h0000 || cnt_m !== 1 || cnt_z !== 1) begin
      bad++;
      $display("FAIL lane_none_read: dout=%h/%h cnt=%0d/%0d, expected 0000 with one pulse", do_m, do_z, cnt_m, cnt_z);
    end
    access(1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'hFF34 || do_z !== 16'hFF34) begin
      bad++;
      $display("FAIL lane_none_write: dout=%h/%h, expected ff34", do_m, do_z);
    end
  endtask

  task automatic test_held_strobe;
    for (int k = 0; k < 2; k++) begin
      access(1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 10);
      total++;
      if (cnt_m !== 1 || cnt_z !== 1 || !busy_hold || !busy_rel || do_m !== 16'hBEEF) begin
        bad++;
        $display("FAIL held_strobe_%0d: cnt=%0d/%0d busy_hold=%0b busy_rel=%0b dout=%h, expected 1/1 1 1 beef",
                 k, cnt_m, cnt_z, busy_hold, busy_rel, do_m);
      end
    end
  endtask

  task automatic test_mmio;
    switches = 16'h3000;
    access(1'b1, 16'h03FF, 16'h1111, 1'b0, 1'b0, 4);
`ifdef SLC3_MMIO_EN
    access(1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'h3000 || do_z !== 16'h3000) begin
      bad++;
      $display("FAIL mmio_switch_read: dout=%h/%h, expected 3000", do_m, do_z);
    end
    access(1'b1, 16'hFFFF, 16'h00A5, 1'b0, 1'b0, 4);
    total++;
    if (hex_m !== 16'h00A5 || hex_z !== 16'h00A5) begin
      bad++;
      $display("FAIL mmio_hex_write: hex=%h/%h, expected 00a5", hex_m, hex_z);
    end
    access(1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'h1111 || do_z !== 16'h1111) begin
      bad++;
      $display("FAIL mmio_array_untouched: dout=%h/%h, expected 1111", do_m, do_z);
    end
`else
    access(1'b1, 16'hFFFF, 16'h00A5, 1'b0, 1'b0, 4);
    access(1'b0, 16'h03FF, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'h00A5 || do_z !== 16'h00A5 || hex_m !== 16'h0000 || hex_z !== 16'h0000) begin
      bad++;
      $display("FAIL ffff_alias: dout=%h/%h hex=%h/%h, expected dout 00a5 hex 0000", do_m, do_z, hex_m, hex_z);
    end
`endif
  endtask

  task automatic test_reset_mid_access;
    access(1'b1, 16'h0030, 16'h0000, 1'b0, 1'b0, 4);
    @(negedge clk);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 16'h0030; wdata = 16'h5555; ub_n = 1'b0; lb_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy_m !== 1'b1 || bus_m.mem_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_in_wait: busy=%b rdy=%b, expected busy=1 rdy=0", busy_m, bus_m.mem_ready);
    end
    @(negedge clk);
    reset_n = 1'b0; ce_n = 1'b1; we_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus_m.mem_ready !== 1'b0 || bus_z.mem_ready !== 1'b0 || busy_m !== 1'b0 || busy_z !== 1'b0 ||
        bus_m.Data_out !== 16'h0000 || bus_z.Data_out !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_state: rdy=%b/%b busy=%b/%b dout=%h/%h, expected all zero",
               bus_m.mem_ready, bus_z.mem_ready, busy_m, busy_z, bus_m.Data_out, bus_z.Data_out);
    end
    @(negedge clk);
    reset_n = 1'b1;
    last_rd = 16'h0000;
    hex_exp = 16'h0000;
    repeat (3) begin
      @(posedge clk); #1;
      total++;
      if (bus_m.mem_ready !== 1'b0 || bus_z.mem_ready !== 1'b0) begin
        bad++;
        $display("FAIL mid_reset_no_pulse: rdy=%b/%b, expected 0/0", bus_m.mem_ready, bus_z.mem_ready);
      end
    end
    access(1'b0, 16'h0030, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'h0000 || do_z !== 16'h0000) begin
      bad++;
      $display("FAIL mid_reset_no_write: dout=%h/%h, expected 0000", do_m, do_z);
    end
  endtask

  task automatic test_aliasing;
    access(1'b1, 16'h0401, 16'hCAFE, 1'b0, 1'b0, 4);
    total++;
    if (pos_z !== 0 || cnt_z !== 1) begin
      bad++;
      $display("FAIL zero_wait_latency: pos=%0d cnt=%0d, expected pos=0 cnt=1", pos_z, cnt_z);
    end
    access(1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 4);
    total++;
    if (do_m !== 16'hCAFE || do_z !== 16'hCAFE) begin
      bad++;
      $display("FAIL alias_read: dout=%h/%h, expected cafe", do_m, do_z);
    end
  endtask

  task automatic test_random;
    int          pool [8];
    logic [15:0] a, d, exp_v;
    logic        u, l;
    bit          wr;
    for (int k = 0; k < 8; k++) begin
      pool[k] = $urandom_range(0, DEPTH - 2);
      access(1'b1, 16'(pool[k]), 16'($urandom), 1'b0, 1'b0, 4);
    end
    for (int n = 0; n < 40; n++) begin
      a  = 16'(($urandom_range(0, 63) << AW) | pool[$urandom_range(0, 7)]);
      d  = 16'($urandom);
      u  = 1'($urandom);
      l  = 1'($urandom);
      wr = 1'($urandom);
      exp_v = wr ? last_rd : model_read(a, u, l);
      access(wr, a, d, u, l, $urandom_range(4, 7));
      total++;
      if (pos_m !== WC || cnt_m !== 1 || pos_z !== 0 || cnt_z !== 1 || !busy_hold || !busy_rel) begin
        bad++;
        $display("FAIL rand_handshake_%0d: pos=%0d/%0d cnt=%0d/%0d busy=%0b/%0b, expected %0d/0 1/1 1/1",
                 n, pos_m, pos_z, cnt_m, cnt_z, busy_hold, busy_rel, WC);
      end
      total++;
      if (do_m !== exp_v || do_z !== exp_v) begin
        bad++;
        $display("FAIL rand_data_%0d: wr=%0b addr=%h dout=%h/%h, expected %h", n, wr, a, do_m, do_z, exp_v);
      end
    end
    total++;
    if (hex_m !== hex_exp || hex_z !== hex_exp) begin
      bad++;
      $display("FAIL hex_final: hex=%h/%h, expected %h", hex_m, hex_z, hex_exp);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_byte_lanes();
    test_held_strobe();
    test_mmio();
    test_reset_mid_access();
    test_aliasing();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/slc3_mem_responder.md
Name: slc3_mem_responder

Overview:
- Memory-side responder for the SLC-3 control unit's memory strobes (Mem_CE/OE/WE/UB/LB, all active-low).
- Decodes each access and inserts a configurable number of wait states.
- Pulses mem_ready once per access and serves reads/writes from an internal word array.
- Optionally maps address 16'hFFFF to the board switches (read) and the hex display register (write), which the LoadPC sequence depends on.

Parameters:
ADDR_W, 10, word-address bits used to index the internal array (depth 2**ADDR_W words of 16 bits)
WAIT_CYCLES, 2, wait states between strobe capture and mem_ready (legal 0..15)

Ports:
Clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset
Mem_CE  input  1  chip enable, active-low
Mem_UB  input  1  upper byte lane enable (bits 15:8), active-low
Mem_LB  input  1  lower byte lane enable (bits 7:0), active-low
Mem_OE  input  1  read strobe, active-low
Mem_WE  input  1  write strobe, active-low
ADDR  input  16  word address from MAR
Data_in  input  16  write data from MDR
Switches  input  16  board switch value (MMIO read source)
Data_out  output  16  read data to MDR
mem_ready  output  1  one-cycle completion pulse
Hex_out  output  16  hex display register (MMIO write target)
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (Reset==0 at an edge): state=IDLE, wait counter=0, Data_out=0, mem_ready=0, Hex_out=0, busy=0. Array contents are not reset.
- States: IDLE, WAIT, READY, HOLD.
- IDLE:
  - Samples strobes each edge. Access starts when Mem_CE==0 and (Mem_WE==0 or Mem_OE==0).
  - Mem_WE==0 gives a write; Mem_WE==0 and Mem_OE==0 together is treated as a write.
  - On start, latch ADDR, Data_in, Mem_UB, Mem_LB and the access type.
  - Load counter with WAIT_CYCLES. Go to WAIT, or go directly to READY if WAIT_CYCLES==0.
- WAIT:
  - Decrement counter each cycle; on reaching 1 go to READY.
  - Strobes are not rechecked here: the access completes even if strobes release early.
- READY (exactly one cycle):
  - mem_ready=1.
  - Write: array[latched addr] updated on the edge leaving READY, enabled lanes only.
  - Read: Data_out is registered on the edge entering READY, so it is valid while mem_ready is high.
  - Next state: HOLD.
- HOLD:
  - mem_ready=0; Data_out held.
  - Return to IDLE when Mem_CE==1 or (Mem_OE==1 and Mem_WE==1).
  - A strobe held low never retriggers.
- Latency: strobe captured at edge N gives mem_ready high during cycle N+1+WAIT_CYCLES (WAIT_CYCLES=0 gives the cycle after capture).
- Byte lanes:
  - Read: disabled lanes return 0.
  - Write: disabled lanes keep their old value.
  - UB=LB=1: write has no effect; read returns 16'h0000. mem_ready still pulses.
- Addressing: array index = ADDR[ADDR_W-1:0]; upper bits ignored, so addresses alias modulo 2**ADDR_W.
- Data_out changes only on read completion or reset. Writes leave Data_out unchanged.
- Reset mid-access: access abandoned. A write that has not yet left READY does not modify the array. mem_ready=0 on the next cycle.
- Counter width: 4 bits.

Optional Feature:
- Macro: SLC3_MMIO_EN.
- Defined:
  - Full 16-bit compare ADDR==16'hFFFF overrides the array.
  - Read returns Switches, sampled on the edge entering READY and lane-masked.
  - Write loads Hex_out with lane-masked Data_in; the array is untouched.
- Undefined:
  - 16'hFFFF aliases to array word 2**ADDR_W-1.
  - Hex_out tied to 16'h0000; Switches ignored.

Test Plan:
1. WAIT_CYCLES=2: write 16'hBEEF to 0x0010 (UB=LB=0, WE low captured at edge 0) -> mem_ready high only in cycle 3. Then read 0x0010 -> Data_out=16'hBEEF during the mem_ready pulse.
2. Byte lanes: write 16'hFFFF to 0x0020, then 16'h1234 with UB=1, LB=0 -> read (UB=LB=0) gives 16'hFF34; read with UB=0, LB=1 gives 16'hFF00.
3. Held strobe: Mem_OE low for 10 cycles -> exactly one mem_ready pulse, busy high until OE returns high. Reissue OE -> second pulse.
4. SLC3_MMIO_EN defined, Switches=16'h3000:
   - read 16'hFFFF -> Data_out=16'h3000;
   - write 16'h00A5 to 16'hFFFF -> Hex_out=16'h00A5, array word 0x3FF unchanged.
   - Undefined: same write then read of 0x03FF -> 16'h00A5.
5. Reset=0 for one cycle while in WAIT of a write of 16'h5555 to 0x0030 (old 16'h0000) -> mem_ready stays 0, Data_out=0, busy=0, later read of 0x0030 returns 16'h0000.
6. ADDR_W=10, WAIT_CYCLES=0: write 16'hCAFE to 0x0401 -> mem_ready the cycle after capture; read 0x0001 returns 16'hCAFE.
